// File: rtl/vga_sync_rx.sv
// -----------------------------------------------------------------------------
// vga_sync_rx
//
// Receive-side VGA timing recovery. Watches an active-low hsync/vsync pair,
// measures the line length and the number of lines per frame, and declares
// lock once the timing has repeated consistently. While locked it regenerates
// pixel coordinates and a data-enable aligned to the incoming syncs.
//
// Ports
//   vgaclk       in   pixel clock, all logic on the rising edge
//   reset        in   asynchronous active-low reset
//   hsync        in   horizontal sync, active-low, synchronous to vgaclk
//   vsync        in   vertical sync, active-low, synchronous to vgaclk
//   x            out  pixel column while de=1, otherwise 0
//   y            out  pixel row while de=1, otherwise 0
//   de           out  active-video strobe (only while locked)
//   locked       out  timing is stable
//   line_len     out  last measured hsync period in cycles
//   frame_lines  out  last measured number of lines per frame
//   sync_err     out  one-cycle pulse on loss of lock or on timeout
// -----------------------------------------------------------------------------
module vga_sync_rx #(
    parameter int HBP         = 48,
    parameter int HACTIVE     = 640,
    parameter int VBP         = 32,
    parameter int VACTIVE     = 480,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       vgaclk,
    input  logic       reset,
    input  logic       hsync,
    input  logic       vsync,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       de,
    output logic       locked,
    output logic [9:0] line_len,
    output logic [9:0] frame_lines,
    output logic       sync_err
);

    localparam logic [9:0] CNT_MAX = 10'h3FF;
    localparam logic [9:0] H_START = 10'(HBP);
    localparam logic [9:0] H_STOP  = 10'(HBP + HACTIVE);
    localparam logic [9:0] V_START = 10'(VBP);
    localparam logic [9:0] V_STOP  = 10'(VBP + VACTIVE);
    localparam logic [7:0] LOCK_N  = 8'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_CHECK   = 2'd2,
        ST_LOCKED  = 2'd3
    } state_t;

    // Position counters stop at all-ones; a stuck counter is reported as a
    // timeout by the FSM instead of wrapping into a bogus measurement.
    function automatic logic [9:0] sat_inc(input logic [9:0] v);
        return (v == CNT_MAX) ? v : v + 10'd1;
    endfunction

    state_t     state_q, state_d;
    logic       hs_q, vs_q;
    logic [9:0] hpos_q, hpos_d;
    logic [9:0] vpos_q, vpos_d;
    logic [9:0] line_len_q, line_len_d;
    logic [9:0] frame_lines_q, frame_lines_d;
    logic [9:0] ref_len_q, ref_len_d;
    logic [9:0] ref_lines_q, ref_lines_d;
    logic [7:0] match_cnt_q, match_cnt_d;
    logic       sync_err_q, sync_err_d;

    logic       hrise, vrise;
    logic       hpos_sat, vpos_sat, timeout;
    logic [9:0] hmeas, vmeas;
    logic [9:0] cap_len;
    logic       h_bad, v_bad;

    // -------------------------------------------------------------------------
    // Edge detection and measurement values for this cycle
    // -------------------------------------------------------------------------
    assign hrise    = ~hs_q & hsync;
    assign vrise    = ~vs_q & vsync;
    assign hpos_sat = (hpos_q == CNT_MAX);
    assign vpos_sat = (vpos_q == CNT_MAX);
    assign timeout  = hpos_sat | vpos_sat;

    // Length of the line ending now, and line count of the frame ending now.
    // A line that ends in the same cycle as the frame still belongs to it.
    assign hmeas = hpos_q + 10'd1;
    assign vmeas = vpos_q + {9'd0, hrise};

    // The final line of a frame may close in the vsync-rise cycle itself, in
    // which case its length is not yet in line_len_q.
    assign cap_len = hrise ? hmeas : line_len_q;

    assign h_bad = hrise & (hmeas != ref_len_q);
    assign v_bad = vrise & (vmeas != ref_lines_q);

    // -------------------------------------------------------------------------
    // Position counters and free-running measurements
    // -------------------------------------------------------------------------
    always_comb begin
        hpos_d        = sat_inc(hpos_q);
        vpos_d        = vpos_q;
        line_len_d    = line_len_q;
        frame_lines_d = frame_lines_q;

        if (hrise) begin
            hpos_d = 10'd0;
        end

        // vsync rise wins over a coincident hsync rise for the row counter.
        if (vrise) begin
            vpos_d = 10'd0;
        end else if (hrise) begin
            vpos_d = sat_inc(vpos_q);
        end

        if (hrise && !hpos_sat) begin
            line_len_d = hmeas;
        end
        if (vrise && !vpos_sat) begin
            frame_lines_d = vmeas;
        end
    end

    // -------------------------------------------------------------------------
    // Lock FSM: next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        ref_len_d   = ref_len_q;
        ref_lines_d = ref_lines_q;
        match_cnt_d = match_cnt_q;
        sync_err_d  = 1'b0;

        unique case (state_q)
            ST_SEARCH: begin
                if (vrise) begin
                    state_d = ST_MEASURE;
                end
            end

            ST_MEASURE: begin
                if (timeout) begin
                    state_d = ST_SEARCH;
                end else if (vrise) begin
                    ref_len_d   = cap_len;
                    ref_lines_d = vmeas;
                    // Only accept a reference that can hold the active window.
                    if ((cap_len >= H_STOP) && (vmeas >= V_STOP)) begin
                        state_d     = ST_CHECK;
                        match_cnt_d = 8'd0;
                    end
                end
            end

            ST_CHECK: begin
                if (timeout) begin
                    state_d    = ST_SEARCH;
                    sync_err_d = 1'b1;
                end else if (h_bad || v_bad) begin
                    // Not yet locked: quietly re-measure.
                    state_d = ST_MEASURE;
                end else if (vrise) begin
                    match_cnt_d = match_cnt_q + 8'd1;
                    if ((match_cnt_q + 8'd1) == LOCK_N) begin
                        state_d = ST_LOCKED;
                    end
                end
            end

            ST_LOCKED: begin
                if (timeout) begin
                    state_d    = ST_SEARCH;
                    sync_err_d = 1'b1;
                end else if (h_bad || v_bad) begin
                    state_d    = ST_MEASURE;
                    sync_err_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_SEARCH;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge vgaclk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_SEARCH;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            hpos_q        <= 10'd0;
            vpos_q        <= 10'd0;
            line_len_q    <= 10'd0;
            frame_lines_q <= 10'd0;
            ref_len_q     <= 10'd0;
            ref_lines_q   <= 10'd0;
            match_cnt_q   <= 8'd0;
            sync_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            hs_q          <= hsync;
            vs_q          <= vsync;
            hpos_q        <= hpos_d;
            vpos_q        <= vpos_d;
            line_len_q    <= line_len_d;
            frame_lines_q <= frame_lines_d;
            ref_len_q     <= ref_len_d;
            ref_lines_q   <= ref_lines_d;
            match_cnt_q   <= match_cnt_d;
            sync_err_q    <= sync_err_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: video timing is decoded straight from the registered counters
    // -------------------------------------------------------------------------
    assign locked      = (state_q == ST_LOCKED);
    assign sync_err    = sync_err_q;
    assign line_len    = line_len_q;
    assign frame_lines = frame_lines_q;

    always_comb begin
        de = locked
           && (hpos_q >= H_START) && (hpos_q < H_STOP)
           && (vpos_q >= V_START) && (vpos_q < V_STOP);
        x  = 10'd0;
        y  = 10'd0;
        if (de) begin
            x = hpos_q - H_START;
            y = vpos_q - V_START;
        end
    end

endmodule

// File: tb/tb_vga_sync_rx.sv
// -----------------------------------------------------------------------------
// tb_vga_sync_rx
//
// Directed bench for vga_sync_rx using a reduced raster so that several frames
// fit in a short run: active window 16x6 with HBP=4, VBP=2. The stream source
// produces lines of ht cycles (hsync low for the first 3) and frames of vt lines
// (vsync low for the first 2 lines). With that source the hsync rise is at
// column 3 and the vsync rise at line 2 column 0.
// -----------------------------------------------------------------------------
module tb_vga_sync_rx;

    localparam int HBP         = 4;
    localparam int HACTIVE     = 16;
    localparam int VBP         = 2;
    localparam int VACTIVE     = 6;
    localparam int LOCK_FRAMES = 2;
    localparam int HSW         = 3;
    localparam int VSW         = 2;

    logic       vgaclk = 1'b0;
    logic       reset  = 1'b1;
    logic       hsync  = 1'b1;
    logic       vsync  = 1'b1;
    logic [9:0] x, y, line_len, frame_lines;
    logic       de, locked, sync_err;

    vga_sync_rx #(
        .HBP        (HBP),
        .HACTIVE    (HACTIVE),
        .VBP        (VBP),
        .VACTIVE    (VACTIVE),
        .LOCK_FRAMES(LOCK_FRAMES)
    ) dut (
        .vgaclk     (vgaclk),
        .reset      (reset),
        .hsync      (hsync),
        .vsync      (vsync),
        .x          (x),
        .y          (y),
        .de         (de),
        .locked     (locked),
        .line_len   (line_len),
        .frame_lines(frame_lines),
        .sync_err   (sync_err)
    );

    always #5 vgaclk = ~vgaclk;

    int n_tests = 0;
    int n_fail  = 0;

    // stream source state
    int ht = 24;
    int vt = 10;
    int hcnt = 0;
    int vcnt = 0;
    bit dead = 1'b0;
    bit short_line = 1'b0;

    // per-window statistics
    int de_cnt, err_cnt, lock_cnt, badxy_cnt;
    int first_v, first_h, first_x, first_y;
    int last_v, last_h, last_x, last_y;
    bit seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clr_stats();
        de_cnt = 0; err_cnt = 0; lock_cnt = 0; badxy_cnt = 0; seen = 1'b0;
        first_v = -1; first_h = -1; first_x = -1; first_y = -1;
        last_v = -1; last_h = -1; last_x = -1; last_y = -1;
    endtask

    // One clock of the stream: drive the current position, sample after the
    // edge, then advance the source.
    task automatic tick();
        hsync = dead ? 1'b1 : (hcnt >= HSW);
        vsync = dead ? 1'b1 : (vcnt >= VSW);
        @(posedge vgaclk);
        #1;
        if (de) begin
            de_cnt++;
            if (!seen) begin
                seen = 1'b1;
                first_v = vcnt; first_h = hcnt; first_x = int'(x); first_y = int'(y);
            end
            last_v = vcnt; last_h = hcnt; last_x = int'(x); last_y = int'(y);
        end else if (x != 10'd0 || y != 10'd0) begin
            badxy_cnt++;
        end
        if (sync_err) err_cnt++;
        if (locked) lock_cnt++;
        hcnt++;
        if (hcnt >= (short_line ? ht - 1 : ht)) begin
            hcnt = 0;
            short_line = 1'b0;
            vcnt = (vcnt + 1 == vt) ? 0 : vcnt + 1;
        end
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Advance at least one cycle, stopping when the source is about to drive (v,h).
    task automatic run_to(input int v, input int h);
        int g;
        g = 0;
        tick();
        while (!(vcnt == v && hcnt == h) && g < 4000) begin
            tick();
            g++;
        end
    endtask

    task automatic restart(input int new_ht, input int new_vt);
        ht = new_ht; vt = new_vt; hcnt = 0; vcnt = 0; dead = 1'b0; short_line = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        clr_stats();

        // ---- reset with toggling syncs ----
        #1 reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            hsync = (i % 2 == 0);
            vsync = (i % 2 != 0);
            @(posedge vgaclk);
            #1;
        end
        chk("rst_x", x, 0);
        chk("rst_y", y, 0);
        chk("rst_de", de, 0);
        chk("rst_locked", locked, 0);
        chk("rst_line_len", line_len, 0);
        chk("rst_frame_lines", frame_lines, 0);
        chk("rst_sync_err", sync_err, 0);

        // ---- release with idle syncs ----
        dead = 1'b1;
        reset = 1'b1;
        clr_stats();
        run_n(20);
        chk("idle_lock_cycles", lock_cnt, 0);
        chk("idle_de_cycles", de_cnt, 0);
        chk("idle_line_len", line_len, 0);
        chk("idle_frame_lines", frame_lines, 0);
        chk("idle_err_cycles", err_cnt, 0);

        // ---- clean 24x10 stream: locks on the 4th vsync rise ----
        restart(24, 10);
        run_to(2, 0);
        run_to(2, 0);
        run_to(2, 0);
        run_to(2, 0);
        chk("lock_not_early", locked, 0);
        tick();
        chk("lock_on_time", locked, 1);
        chk("lock_line_len", line_len, 24);
        chk("lock_frame_lines", frame_lines, 10);

        // ---- one locked frame ----
        clr_stats();
        run_n(240);
        chk("frame_de_count", de_cnt, 96);
        chk("frame_first_v", first_v, 3);
        chk("frame_first_h", first_h, 7);
        chk("frame_first_x", first_x, 0);
        chk("frame_first_y", first_y, 0);
        chk("frame_last_v", last_v, 8);
        chk("frame_last_h", last_h, 22);
        chk("frame_last_x", last_x, 15);
        chk("frame_last_y", last_y, 5);
        chk("frame_xy_zero_outside", badxy_cnt, 0);
        chk("frame_locked_all", lock_cnt, 240);
        chk("frame_no_err", err_cnt, 0);

        // ---- single 23-cycle line while locked ----
        run_to(5, 0);
        short_line = 1'b1;
        run_n(26);
        chk("bad_before_err", sync_err, 0);
        chk("bad_before_locked", locked, 1);
        tick();
        chk("bad_err_pulse", sync_err, 1);
        chk("bad_unlocked", locked, 0);
        chk("bad_de_off", de, 0);
        chk("bad_line_len", line_len, 23);
        tick();
        chk("bad_err_one_cycle", sync_err, 0);
        clr_stats();
        run_to(2, 0);
        run_to(2, 0);
        run_to(2, 0);
        chk("relock_not_early", locked, 0);
        tick();
        chk("relock_on_time", locked, 1);
        chk("relock_no_err", err_cnt, 0);

        // ---- dead syncs while locked: timeout after 1023 cycles ----
        run_n(3);
        dead = 1'b1;
        clr_stats();
        run_n(1023);
        chk("dead_err_not_early", err_cnt, 0);
        chk("dead_still_locked", locked, 1);
        tick();
        chk("dead_err_pulse", sync_err, 1);
        chk("dead_unlocked", locked, 0);
        tick();
        chk("dead_err_one_cycle", sync_err, 0);
        run_n(50);
        chk("dead_stays_unlocked", locked, 0);
        chk("dead_err_total", err_cnt, 1);

        // ---- line too short for the active window: never locks ----
        restart(18, 10);
        clr_stats();
        run_n(18 * 10 * 6);
        chk("short_line_never_locks", lock_cnt, 0);
        chk("short_line_no_err", err_cnt, 0);
        chk("short_line_len", line_len, 18);
        chk("short_line_frame", frame_lines, 10);

        // ---- frame too short for the active window: never locks ----
        restart(24, 7);
        clr_stats();
        run_n(24 * 7 * 6);
        chk("short_frame_never_locks", lock_cnt, 0);
        chk("short_frame_lines", frame_lines, 7);
        chk("short_frame_line_len", line_len, 24);

        // ---- 25x11 stream ----
        restart(25, 11);
        g = 0;
        while (!locked && g < 4000) begin
            tick();
            g++;
        end
        chk("lock25_reached", locked, 1);
        chk("lock25_line_len", line_len, 25);
        chk("lock25_frame_lines", frame_lines, 11);
        clr_stats();
        run_n(275);
        chk("lock25_de_count", de_cnt, 96);
        chk("lock25_first_xy", {first_x[15:0], first_y[15:0]}, 32'h0000_0000);
        chk("lock25_last_x", last_x, 15);
        chk("lock25_last_y", last_y, 5);
        chk("lock25_no_err", err_cnt, 0);

        // ---- mid-frame reset while locked at x=10, y=3 ----
        g = 0;
        while (!(de && x == 10'd10 && y == 10'd3) && g < 400) begin
            tick();
            g++;
        end
        chk("mrst_point_found", (de && x == 10'd10 && y == 10'd3), 1);
        reset = 1'b0;
        #1;
        chk("mrst_de", de, 0);
        chk("mrst_x", x, 0);
        chk("mrst_y", y, 0);
        chk("mrst_locked", locked, 0);
        chk("mrst_line_len", line_len, 0);
        chk("mrst_frame_lines", frame_lines, 0);
        run_n(3);
        reset = 1'b1;
        clr_stats();
        run_to(2, 0);
        run_to(2, 0);
        run_to(2, 0);
        run_to(2, 0);
        chk("mrst_relock_not_early", locked, 0);
        tick();
        chk("mrst_relock_on_time", locked, 1);
        chk("mrst_relock_line_len", line_len, 25);
        chk("mrst_relock_frame_lines", frame_lines, 11);
        chk("mrst_relock_no_err", err_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
